// File: rtl/rc5_decrypt_if.sv
// Request/response bundle between the RC5 block driver and rc5_decrypt.
// The master drives the request fields; the slave returns status and the result.
interface rc5_decrypt_if;
    logic        start_i;
    logic [4:0]  num_rounds_i;
    logic [31:0] ct_i;
    logic        mode_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] pt_o;

    modport master (
        output start_i, num_rounds_i, ct_i, mode_i,
        input  busy_o, done_o, err_o, pt_o
    );

    modport slave (
        input  start_i, num_rounds_i, ct_i, mode_i,
        output busy_o, done_o, err_o, pt_o
    );
endinterface

// File: rtl/rc5_decrypt.sv
// Iterative RC5-16 decryptor, one round per clock, fed by the keygen subkey table.
// Define RC5_ENC_MODE_EN to add an encrypt path selected by mode_i (decrypt-only otherwise).
module rc5_decrypt #(
    parameter int W     = 16,
    parameter int T_MAX = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ready_i,
    input  logic [W-1:0] subkeys_i [0:T_MAX-1],
    output logic         keys_valid_o,
    rc5_decrypt_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [4:0] MAX_ROUNDS = 5'd16;

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] d;
        d = {x, x} >> s;
        return d[15:0];
    endfunction

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] pt_q, pt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        keys_valid_q, keys_valid_d;

    logic        start_ok;
    logic [4:0]  k_base;
    logic [15:0] s_even, s_odd;
    logic [15:0] a_dec, b_dec;
    logic [15:0] a_nxt, b_nxt;
    logic [31:0] pt_fin;

`ifdef RC5_ENC_MODE_EN
    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] d;
        d = {x, x} << s;
        return d[31:16];
    endfunction

    logic        mode_q, mode_d;
    logic [4:0]  r_q, r_d;
    logic [15:0] a_enc, b_enc;
`else
    logic unused_mode;
    assign unused_mode = bus.mode_i;
`endif

    assign start_ok = keys_valid_q && (bus.num_rounds_i <= MAX_ROUNDS);

    // Decrypt walks rounds r..1; encrypt walks 1..r, derived from the down-counter.
    always_comb begin
        k_base = cnt_q;
`ifdef RC5_ENC_MODE_EN
        if (mode_q) k_base = r_q - cnt_q + 5'd1;
`endif
    end

    assign s_even = subkeys_i[{k_base, 1'b0}];
    assign s_odd  = subkeys_i[{k_base, 1'b1}];

    assign b_dec = rotr16(b_q - s_odd, a_q[3:0]) ^ a_q;
    assign a_dec = rotr16(a_q - s_even, b_dec[3:0]) ^ b_dec;

`ifdef RC5_ENC_MODE_EN
    assign a_enc  = rotl16(a_q ^ b_q, b_q[3:0]) + s_even;
    assign b_enc  = rotl16(b_q ^ a_enc, a_enc[3:0]) + s_odd;
    assign a_nxt  = mode_q ? a_enc : a_dec;
    assign b_nxt  = mode_q ? b_enc : b_dec;
    // Encryption whitens on accept, so its final step only publishes A/B.
    assign pt_fin = mode_q ? {a_q, b_q} : {a_q - subkeys_i[0], b_q - subkeys_i[1]};
`else
    assign a_nxt  = a_dec;
    assign b_nxt  = b_dec;
    assign pt_fin = {a_q - subkeys_i[0], b_q - subkeys_i[1]};
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        pt_d         = pt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        keys_valid_d = keys_valid_q | key_ready_i;
`ifdef RC5_ENC_MODE_EN
        mode_d       = mode_q;
        r_d          = r_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (start_ok) begin
                        a_d     = bus.ct_i[31:16];
                        b_d     = bus.ct_i[15:0];
                        cnt_d   = bus.num_rounds_i;
                        busy_d  = 1'b1;
                        state_d = (bus.num_rounds_i == 5'd0) ? S_FINAL : S_ROUND;
`ifdef RC5_ENC_MODE_EN
                        mode_d  = bus.mode_i;
                        r_d     = bus.num_rounds_i;
                        if (bus.mode_i) begin
                            a_d = bus.ct_i[31:16] + subkeys_i[0];
                            b_d = bus.ct_i[15:0] + subkeys_i[1];
                        end
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ROUND: begin
                a_d   = a_nxt;
                b_d   = b_nxt;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = S_FINAL;
            end
            S_FINAL: begin
                pt_d    = pt_fin;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples the pre-edge _d values.
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            pt_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            keys_valid_q <= 1'b0;
`ifdef RC5_ENC_MODE_EN
            mode_q       <= 1'b0;
            r_q          <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            pt_q         <= pt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            keys_valid_q <= keys_valid_d;
`ifdef RC5_ENC_MODE_EN
            mode_q       <= mode_d;
            r_q          <= r_d;
`endif
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.err_o    = err_q;
    assign bus.pt_o     = pt_q;
    assign keys_valid_o = keys_valid_q;

endmodule

// File: tb/tb_rc5_decrypt.sv
// Self-checking bench for rc5_decrypt: RC5-16 reference model with key schedule,
// randomized round-trip runs, reject paths, latency and mid-operation reset.
module tb_rc5_decrypt;

    logic        clk;
    logic        rst;
    logic        key_ready;
    logic [15:0] sk [0:33];
    logic        keys_valid;

    int checks = 0;
    int errors = 0;

    rc5_decrypt_if bus ();

    rc5_decrypt dut (
        .clk          (clk),
        .rst          (rst),
        .key_ready_i  (key_ready),
        .subkeys_i    (sk),
        .keys_valid_o (keys_valid),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_rotl(input logic [15:0] x, input logic [15:0] amt);
        int v, sh;
        v  = int'(x);
        sh = int'(amt[3:0]);
        return 16'(((v << sh) | (v >> (16 - sh))) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] m_rotr(input logic [15:0] x, input logic [15:0] amt);
        int v, sh;
        v  = int'(x);
        sh = int'(amt[3:0]);
        return 16'(((v >> sh) | (v << (16 - sh))) & 32'hFFFF);
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] p, input int r);
        logic [15:0] a, b;
        a = p[31:16] + sk[0];
        b = p[15:0] + sk[1];
        for (int i = 1; i <= r; i++) begin
            a = m_rotl(a ^ b, b) + sk[2*i];
            b = m_rotl(b ^ a, a) + sk[2*i+1];
        end
        return {a, b};
    endfunction

    function automatic logic [31:0] model_dec(input logic [31:0] c, input int r);
        logic [15:0] a, b;
        a = c[31:16];
        b = c[15:0];
        for (int i = r; i >= 1; i--) begin
            b = m_rotr(b - sk[2*i+1], a) ^ a;
            a = m_rotr(a - sk[2*i], b) ^ b;
        end
        b = b - sk[1];
        a = a - sk[0];
        return {a, b};
    endfunction

    // RC5 key expansion for the byte key 00,01,..,0F.
    task automatic keygen_model(input int r);
        logic [15:0] l [0:7];
        logic [15:0] a, b;
        int t, i, j, n;
        t = 2 * (r + 1);
        for (int k = 0; k < 8; k++) l[k] = {8'(2*k+1), 8'(2*k)};
        for (int k = 0; k < 34; k++) sk[k] = 16'h0000;
        sk[0] = 16'hB7E1;
        for (int k = 1; k < t; k++) sk[k] = sk[k-1] + 16'h9E37;
        a = 16'h0; b = 16'h0; i = 0; j = 0;
        n = 3 * ((t > 8) ? t : 8);
        for (int k = 0; k < n; k++) begin
            a = m_rotl(sk[i] + a + b, 16'd3);
            sk[i] = a;
            b = m_rotl(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % 8;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_key();
        @(negedge clk);
        key_ready = 1'b1;
        @(posedge clk);
        #1 key_ready = 1'b0;
    endtask

    // Issues one start and observes until done_o or a 60-cycle bound; lat=-1 on timeout.
    task automatic run_block(input logic [4:0] r, input logic [31:0] ct, input logic mode,
                             input bit poke, output logic [31:0] pt, output int lat,
                             output int busy_n, output int err_n);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.num_rounds_i = r;
        bus.ct_i         = ct;
        bus.mode_i       = mode;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.ct_i    = $urandom;
        lat = -1; busy_n = 0; err_n = 0; pt = 32'h0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.busy_o) busy_n++;
            if (bus.err_o) err_n++;
            if (bus.done_o) begin
                lat = k;
                pt  = bus.pt_o;
            end
            bus.start_i = poke && bus.busy_o && ($urandom_range(0, 1) == 1);
            if (poke) bus.num_rounds_i = 5'($urandom_range(0, 31));
        end
        bus.start_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.busy_o, bus.done_o, bus.err_o, keys_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.busy_o, bus.done_o, bus.err_o, keys_valid});
        end
        checks++;
        if (bus.pt_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_pt: got %h expected 00000000", bus.pt_o);
        end
    endtask

    task automatic test_no_keys();
        int err_n, busy_n;
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_rounds_i = 5'd4; bus.ct_i = 32'hCAFEF00D; bus.mode_i = 1'b0;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        err_n = 0; busy_n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.err_o) err_n++;
            if (bus.busy_o) busy_n++;
        end
        checks++;
        if (err_n !== 1) begin
            errors++;
            $display("FAIL nokey_err_pulses: got %0d expected 1", err_n);
        end
        checks++;
        if (busy_n !== 0) begin
            errors++;
            $display("FAIL nokey_busy: got %0d busy cycles expected 0", busy_n);
        end
        checks++;
        if (bus.pt_o !== 32'h0) begin
            errors++;
            $display("FAIL nokey_pt: got %h expected 00000000", bus.pt_o);
        end
    endtask

    task automatic test_same_cycle_key();
        int err_n;
        @(negedge clk);
        key_ready = 1'b1; bus.start_i = 1'b1; bus.num_rounds_i = 5'd2;
        @(posedge clk);
        #1 key_ready = 1'b0; bus.start_i = 1'b0;
        err_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.err_o) err_n++;
        end
        checks++;
        if (err_n !== 1) begin
            errors++;
            $display("FAIL samecycle_err: got %0d pulses expected 1", err_n);
        end
        checks++;
        if (keys_valid !== 1'b1) begin
            errors++;
            $display("FAIL samecycle_keys_valid: got %b expected 1", keys_valid);
        end
    endtask

    task automatic test_r0();
        logic [31:0] pt;
        int lat, busy_n, err_n;
        for (int k = 0; k < 34; k++) sk[k] = 16'h0000;
        sk[0] = 16'h0001; sk[1] = 16'h0002;
        pulse_key();
        run_block(5'd0, 32'h12355679, 1'b0, 1'b0, pt, lat, busy_n, err_n);
        checks++;
        if (pt !== 32'h12345677) begin
            errors++;
            $display("FAIL r0_pt: got %h expected 12345677", pt);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL r0_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_r1_zero_keys();
        logic [31:0] pt;
        int lat, busy_n, err_n;
        for (int k = 0; k < 34; k++) sk[k] = 16'h0000;
        run_block(5'd1, 32'h00010010, 1'b0, 1'b0, pt, lat, busy_n, err_n);
        checks++;
        if (pt !== 32'h00890009) begin
            errors++;
            $display("FAIL r1_pt: got %h expected 00890009", pt);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL r1_latency: got %0d expected 3", lat);
        end
        checks++;
        if (busy_n !== 2) begin
            errors++;
            $display("FAIL r1_busy_cycles: got %0d expected 2", busy_n);
        end
    endtask

    task automatic test_keygen_roundtrip();
        logic [31:0] p, ct, pt;
        int lat, busy_n, err_n, r;
        for (int sel = 0; sel < 2; sel++) begin
            r = (sel == 0) ? 12 : 16;
            keygen_model(r);
            for (int n = 0; n < 3; n++) begin
                p  = $urandom;
                ct = model_enc(p, r);
                run_block(5'(r), ct, 1'b0, 1'b1, pt, lat, busy_n, err_n);
                checks++;
                if (pt !== p) begin
                    errors++;
                    $display("FAIL roundtrip_r%0d: got %h expected %h", r, pt, p);
                end
                checks++;
                if (lat !== r + 2 || busy_n !== r + 1 || err_n !== 0) begin
                    errors++;
                    $display("FAIL timing_r%0d: got lat=%0d busy=%0d err=%0d expected lat=%0d busy=%0d err=0",
                             r, lat, busy_n, err_n, r + 2, r + 1);
                end
            end
        end
    endtask

    task automatic test_random_keys();
        logic [31:0] ct, pt;
        int lat, busy_n, err_n, r;
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 34; k++) sk[k] = 16'($urandom);
            r  = $urandom_range(0, 16);
            ct = $urandom;
            run_block(5'(r), ct, 1'b0, 1'b0, pt, lat, busy_n, err_n);
            checks++;
            if (pt !== model_dec(ct, r) || lat !== r + 2) begin
                errors++;
                $display("FAIL random_dec_r%0d: got %h lat=%0d expected %h lat=%0d",
                         r, pt, lat, model_dec(ct, r), r + 2);
            end
        end
    endtask

    task automatic test_bad_rounds();
        logic [31:0] pt_before;
        int err_n, busy_n;
        pt_before = bus.pt_o;
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_rounds_i = 5'd17; bus.ct_i = 32'h01234567;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        err_n = 0; busy_n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.err_o) err_n++;
            if (bus.busy_o || bus.done_o) busy_n++;
        end
        checks++;
        if (err_n !== 1 || busy_n !== 0) begin
            errors++;
            $display("FAIL r17_reject: got err=%0d busy/done=%0d expected err=1 busy/done=0",
                     err_n, busy_n);
        end
        checks++;
        if (bus.pt_o !== pt_before) begin
            errors++;
            $display("FAIL r17_pt_held: got %h expected %h", bus.pt_o, pt_before);
        end
    endtask

    task automatic test_reset_mid();
        int done_n;
        keygen_model(16);
        @(negedge clk);
        bus.start_i = 1'b1; bus.num_rounds_i = 5'd16; bus.ct_i = $urandom;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, keys_valid} !== 3'b000 || bus.pt_o !== 32'h0) begin
            errors++;
            $display("FAIL midreset: got busy=%b done=%b kv=%b pt=%h expected 0 0 0 00000000",
                     bus.busy_o, bus.done_o, keys_valid, bus.pt_o);
        end
        rst = 1'b0;
        done_n = 0;
        repeat (24) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) done_n++;
        end
        checks++;
        if (done_n !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d busy/done cycles expected 0", done_n);
        end
    endtask

`ifdef RC5_ENC_MODE_EN
    task automatic test_encrypt();
        logic [31:0] ct, pt;
        int lat, busy_n, err_n;
        keygen_model(12);
        pulse_key();
        run_block(5'd12, 32'hDEADBEEF, 1'b1, 1'b0, ct, lat, busy_n, err_n);
        checks++;
        if (ct !== model_enc(32'hDEADBEEF, 12) || lat !== 14) begin
            errors++;
            $display("FAIL enc_r12: got %h lat=%0d expected %h lat=14",
                     ct, lat, model_enc(32'hDEADBEEF, 12));
        end
        run_block(5'd12, ct, 1'b0, 1'b0, pt, lat, busy_n, err_n);
        checks++;
        if (pt !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL enc_dec_roundtrip: got %h expected deadbeef", pt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        key_ready = 1'b0;
        bus.start_i = 1'b0;
        bus.num_rounds_i = 5'd0;
        bus.ct_i = 32'h0;
        bus.mode_i = 1'b0;
        for (int k = 0; k < 34; k++) sk[k] = 16'h0000;

        test_reset();
        test_no_keys();
        test_same_cycle_key();
        test_r0();
        test_r1_zero_keys();
        test_keygen_roundtrip();
        test_random_keys();
        test_bad_rounds();
        test_reset_mid();
`ifdef RC5_ENC_MODE_EN
        test_encrypt();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc5_decrypt.md
# rc5_decrypt

Iterative RC5-16 block decryptor that consumes the subkey table produced by `keygen` and inverts RC5 encryption one round per clock. It sits downstream of `keygen` in the accelerator datapath: `keygen` fills S[0..2r+1] and pulses `ready`, after which this block accepts 32-bit ciphertext blocks and returns plaintext. Word size w=16, rotation amounts use the low 4 bits, and all arithmetic is modulo 2^16.

## Interface
- `W`, 16, word size in bits (fixed; other values unsupported)
- `T_MAX`, 34, subkey table depth = 2*(16+1)
- `clk` input 1: clock
- `rst` input 1: reset, synchronous, active-high
- `key_ready_i` input 1: one-cycle pulse from `keygen` `ready`; marks the subkey table valid
- `subkeys_i` input `W` x [0:T_MAX-1]: unpacked subkey table S, connected directly to `keygen` `subkeys`
- `num_rounds_i` input 5: round count r, legal range 0..16; sampled on start
- `start_i` input 1: request; sampled only in IDLE
- `ct_i` input 32: ciphertext; A=ct_i[31:16], B=ct_i[15:0]; sampled on start
- `mode_i` input 1: 0=decrypt, 1=encrypt (honoured only with `RC5_ENC_MODE_EN`)
- `busy_o` output 1: high in ROUND and FINAL
- `done_o` output 1: one-cycle pulse, result valid
- `err_o` output 1: one-cycle pulse, start rejected
- `pt_o` output 32: result, same A/B packing; held until the next accepted start
- `keys_valid_o` output 1: sticky subkey-valid flag

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- `keys_valid_o` is set on any `key_ready_i` pulse, in any state, and cleared only by `rst`.
- IDLE: when `start_i` is high and `keys_valid_o`=1 and `num_rounds_i`<=16, latch A, B, r=`num_rounds_i`, cnt=r, and mode. Go to ROUND if r>0, otherwise go to FINAL.
- IDLE reject: when `start_i` is high and either `keys_valid_o`=0 or `num_rounds_i`>16, pulse `err_o` on the next cycle and stay in IDLE. A, B and `pt_o` are unchanged.
- ROUND (decrypt), for the current cnt:
  - B' = ROTR(B - S[2cnt+1], A[3:0]) ^ A
  - A' = ROTR(A - S[2cnt], B'[3:0]) ^ B'
  - cnt decrements; on cnt==1 go to FINAL.
- FINAL (decrypt): B = B - S[1]; A = A - S[0]; `pt_o` <= {A,B}; go to DONE.
- DONE: `done_o`=1 for this cycle only; go to IDLE.
- `start_i` is ignored outside IDLE and does not raise `err_o`.
- `subkeys_i` must be stable while `busy_o`=1; the upstream must not restart `keygen` while busy.
- S indices never exceed 2r+1 <= 33.
- No in-flight abort exists; `rst` is the only abort.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, `err_o`=0, `pt_o`=0, `keys_valid_o`=0, internal A/B/cnt=0.
- Reset mid-operation: returns to IDLE on the next edge and clears `keys_valid_o`; the upstream must rerun `keygen`.
- Accepted start sampled at edge n:
  - `busy_o` is high from edge n to edge n+r+1.
  - `done_o` is high in the cycle after edge n+r+1.
  - The block is back in IDLE after edge n+r+2.
  - Throughput: one block per r+3 cycles.
- r=0: ROUND is skipped; `done_o` is high in the cycle after edge n+1.
- `key_ready_i` and `start_i` in the same IDLE cycle with `keys_valid_o`=0: the start is rejected because the flag is not yet set.
- `pt_o` updates only at the FINAL edge.
- `err_o` and `done_o` are never high together.

## Configuration
- `RC5_ENC_MODE_EN` defined: `mode_i`=1 is latched on start and selects encryption.
  - Encryption runs FINAL-first: A = A + S[0]; B = B + S[1].
  - Then for cnt = 1..r: A = ROTL(A^B, B[3:0]) + S[2cnt]; B = ROTL(B^A, A[3:0]) + S[2cnt+1].
  - Encryption has the same state count and latency as decryption.
- `RC5_ENC_MODE_EN` undefined: `mode_i` is ignored and the block is decrypt-only. Only decrypt datapath logic is synthesized.

## Test plan
- Reset, then start with `num_rounds_i`=4 and no `key_ready_i` -> `err_o` pulses once, `busy_o` stays 0, `pt_o`=0x00000000.
- Pulse `key_ready_i`; S[0]=0x0001, S[1]=0x0002; r=0; `ct_i`=0x12355679 -> `done_o` at start+2, `pt_o`=0x12345677.
- All subkeys 0x0000; r=1; `ct_i`=0x00010010 -> `pt_o`=0x00890009, `done_o` at start+3, `busy_o` high for 2 cycles.
- Full run: r=12 and 16 from `keygen` (key 0x00..0F). Encrypt in the model, decrypt in the DUT -> round-trip match, `done_o` at start+r+2; toggle `start_i` while busy -> no effect.
- `num_rounds_i`=17 with keys valid -> `err_o` pulse, state stays IDLE, previous `pt_o` held.
- Assert `rst` during ROUND at r=16 -> next cycle `busy_o`=0, `keys_valid_o`=0, `pt_o`=0, no `done_o`; with `RC5_ENC_MODE_EN`, encrypt then decrypt of 0xDEADBEEF at r=12 returns 0xDEADBEEF.
